// File: rtl/gfx_pkg.sv
// Shared playfield definitions.
//   PF_ADDR_W    - playfield address width
//   PF_TILES     - number of tiles in the playfield
//   fill_state_t - fill engine FSM states
package gfx_pkg;
    localparam int PF_ADDR_W = 10;
    localparam int PF_TILES  = 1024;

    typedef enum logic [1:0] {IDLE, ARM, FILL, DONE} fill_state_t;
endpackage

// File: rtl/pf_fill_engine.sv
// Fill engine: writes a constant tile ID over an address range of the playfield.
// Ports:
//   clk, rst_l       - clock, asynchronous active-low reset
//   vblank           - vertical blank; gates fill requests when VBLANK_ONLY
//   start            - one-cycle pulse, latches base/len/value (IDLE only)
//   base, len, value - first address, tile count (0..2^ADDR_W), tile ID
//   grant            - arbiter accepted the fill write this cycle
//   fill_req         - engine wants the RAM port this cycle
//   cur_addr,value_q - address/data of the pending fill write
//   busy, done       - in ARM/FILL; one-cycle completion pulse
module pf_fill_engine
    import gfx_pkg::*;
#(
    parameter int ADDR_W      = PF_ADDR_W,
    parameter bit VBLANK_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              vblank,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        value,
    input  logic              grant,
    output logic              fill_req,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [7:0]        value_q,
    output logic              busy,
    output logic              done
);
    fill_state_t     state, state_nxt;
    logic [ADDR_W:0] remaining;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
                if (len == '0)                  state_nxt = DONE;
                else if (VBLANK_ONLY && !vblank) state_nxt = ARM;
                else                             state_nxt = FILL;
            end
            ARM:  if (vblank) state_nxt = FILL;
            FILL: if (grant && remaining == (ADDR_W+1)'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cur_addr wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cur_addr  <= '0;
            remaining <= '0;
            value_q   <= '0;
        end else if (state == IDLE && start) begin
            cur_addr  <= base;
            remaining <= len;
            value_q   <= value;
        end else if (state == FILL && grant) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
        end
    end

    // Outside vblank the engine stays in FILL but stops requesting
    assign fill_req = (state == FILL) && (vblank || !VBLANK_ONLY);
    assign busy     = (state == ARM) || (state == FILL);
    assign done     = (state == DONE);
endmodule

// File: rtl/pf_port_arbiter.sv
// Shares the playfield RAM A port between the CPU bus and the fill engine.
// CPU wins, except that after STARVE_LIMIT consecutive cycles in which the
// fill engine was blocked by the CPU, the fill engine takes one cycle.
// Ports:
//   clk, rst_l                    - clock, asynchronous active-low reset
//   cpu_cs_l/we_l/addr/wdata      - CPU request (active-low strobes)
//   cpu_rdata                     - RAM read data, valid the cycle after a granted read
//   cpu_wait                      - CPU not granted this cycle, must hold request
//   vblank                        - vertical blank from VGA timing
//   fill_start/base/len/value     - fill command
//   fill_busy, fill_done          - fill status
//   ram_cs_l/we_l/addr/wdata      - RAM A port (combinational from the grant)
//   ram_rdata                     - RAM A read data (1-cycle synchronous)
module pf_port_arbiter
    import gfx_pkg::*;
#(
    parameter int ADDR_W       = PF_ADDR_W,
    parameter int STARVE_LIMIT = 4,
    parameter bit VBLANK_ONLY  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              cpu_cs_l,
    input  logic              cpu_we_l,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait,
    input  logic              vblank,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [7:0]        fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_cs_l,
    output logic              ram_we_l,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic              fill_req, fill_gnt, cpu_gnt, cpu_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [7:0]        fill_data;
    logic [SW-1:0]     starve, starve_nxt;

    pf_fill_engine #(
        .ADDR_W      (ADDR_W),
        .VBLANK_ONLY (VBLANK_ONLY)
    ) u_fill (
        .clk      (clk),
        .rst_l    (rst_l),
        .vblank   (vblank),
        .start    (fill_start),
        .base     (fill_base),
        .len      (fill_len),
        .value    (fill_value),
        .grant    (fill_gnt),
        .fill_req (fill_req),
        .cur_addr (fill_addr),
        .value_q  (fill_data),
        .busy     (fill_busy),
        .done     (fill_done)
    );

    assign cpu_req = !cpu_cs_l;

    // starve counts cycles the fill engine wanted the port but lost to the CPU
    always_comb begin
        fill_gnt   = 1'b0;
        cpu_gnt    = 1'b0;
        starve_nxt = '0;
        if (cpu_req && fill_req && starve == LIM) begin
            fill_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
            if (fill_req) starve_nxt = (starve == LIM) ? starve : starve + SW'(1);
        end else if (fill_req) begin
            fill_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) starve <= '0;
        else        starve <= starve_nxt;
    end

    always_comb begin
        ram_cs_l  = 1'b1;
        ram_we_l  = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_cs_l  = 1'b0;
            ram_we_l  = cpu_we_l;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (fill_gnt) begin
            ram_cs_l  = 1'b0;
            ram_we_l  = 1'b0;
            ram_addr  = fill_addr;
            ram_wdata = fill_data;
        end
    end

    assign cpu_wait  = cpu_req && fill_gnt;
    assign cpu_rdata = ram_rdata;
endmodule

// File: tb/tb_pf_port_arbiter.sv
module tb_pf_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_l;
    logic        cpu_cs_l, cpu_we_l;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_wait, vblank, fill_start;
    logic [9:0]  fill_base;
    logic [10:0] fill_len;
    logic [7:0]  fill_value;
    logic        fill_busy, fill_done;
    logic        ram_cs_l, ram_we_l;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    pf_port_arbiter dut (
        .clk(clk), .rst_l(rst_l),
        .cpu_cs_l(cpu_cs_l), .cpu_we_l(cpu_we_l), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .vblank(vblank), .fill_start(fill_start), .fill_base(fill_base),
        .fill_len(fill_len), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_cs_l(ram_cs_l), .ram_we_l(ram_we_l), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // playfield RAM model: synchronous write, registered read
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (!ram_cs_l) begin
            if (!ram_we_l) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic       cs_l, we_l;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       e_cs_l, e_we_l;
        logic [9:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_wait;
    } vec_t;
    vec_t vecs[6];

    int checks = 0, errors = 0;
    int done_cnt = 0, wr_cnt = 0;
    int wr_hits[1024];
    logic       s_cs_l, s_we_l, s_wait, s_busy, s_done;
    logic [9:0] s_addr;
    logic [7:0] s_wdata, s_rdata;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock cycle: sample mid-cycle, score any RAM write, return just after posedge
    task automatic tick();
        wr_t e;
        @(negedge clk);
        s_cs_l = ram_cs_l; s_we_l = ram_we_l; s_addr = ram_addr; s_wdata = ram_wdata;
        s_wait = cpu_wait; s_busy = fill_busy; s_done = fill_done; s_rdata = cpu_rdata;
        if (fill_done) done_cnt++;
        if (rst_l && !ram_cs_l && !ram_we_l) begin
            wr_cnt++;
            wr_hits[ram_addr]++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", ram_addr, e.addr);
                chk("write_data", ram_wdata, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_cs_l"}, s_cs_l, 1);
        chk({nm, "_we_l"}, s_we_l, 1);
        chk({nm, "_addr"}, s_addr, 0);
        chk({nm, "_wdata"}, s_wdata, 0);
        chk({nm, "_wait"}, s_wait, 0);
        chk({nm, "_busy"}, s_busy, 0);
        chk({nm, "_done"}, s_done, 0);
    endtask

    task automatic start_fill(input logic [9:0] b, input logic [10:0] l, input logic [7:0] v);
        fill_base = b; fill_len = l; fill_value = v; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, bad, n;
        bit seen;
        for (int i = 0; i < 1024; i++) wr_hits[i] = 0;
        //            cs we addr    wdata  e_cs e_we e_addr  e_wdata e_wait
        vecs[0] = '{1'b1, 1'b1, 10'h155, 8'h99, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 10'h123, 8'h77, 1'b0, 1'b0, 10'h123, 8'h77, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 10'h3FF, 8'h01, 1'b0, 1'b0, 10'h3FF, 8'h01, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 10'h000, 8'hFE, 1'b0, 1'b0, 10'h000, 8'hFE, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 10'h2AA, 8'h33, 1'b0, 1'b1, 10'h2AA, 8'h33, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 10'h3FF, 8'h42, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0};

        rst_l = 1'b0; cpu_cs_l = 1'b1; cpu_we_l = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        vblank = 1'b1; fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
        tick(); tick();
        chk_reset_vals("reset");
        rst_l = 1'b1;
        tick();

        // CPU pass-through with the fill engine idle
        foreach (vecs[i]) begin
            cpu_cs_l = vecs[i].cs_l; cpu_we_l = vecs[i].we_l;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            if (!vecs[i].cs_l && !vecs[i].we_l) push_wr(vecs[i].addr, vecs[i].wdata);
            tick();
            chk($sformatf("vec%0d_cs_l", i), s_cs_l, vecs[i].e_cs_l);
            chk($sformatf("vec%0d_we_l", i), s_we_l, vecs[i].e_we_l);
            chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_wdata", i), s_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d_wait", i), s_wait, vecs[i].e_wait);
        end

        // CPU read of 0x123, data the following cycle
        cpu_cs_l = 1'b0; cpu_we_l = 1'b1; cpu_addr = 10'h123;
        tick();
        chk("rd_wait", s_wait, 0);
        chk("rd_cs_l", s_cs_l, 0);
        chk("rd_we_l", s_we_l, 1);
        cpu_cs_l = 1'b1;
        tick();
        chk("rd_data", s_rdata, 8'h77);

        // Wrapping fill, with a second start mid-fill that must be ignored
        vblank = 1'b1;
        d0 = done_cnt;
        push_wr(10'h3FE, 8'h5A); push_wr(10'h3FF, 8'h5A);
        push_wr(10'h000, 8'h5A); push_wr(10'h001, 8'h5A);
        start_fill(10'h3FE, 11'd4, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                fill_base = 10'h100; fill_len = 11'd2; fill_value = 8'hFF; fill_start = 1'b1;
            end else fill_start = 1'b0;
            tick();
            chk($sformatf("wrap%0d_cs_l", i), s_cs_l, 0);
            chk($sformatf("wrap%0d_addr", i), s_addr, 10'(10'h3FE + 10'(i)));
            chk($sformatf("wrap%0d_busy", i), s_busy, 1);
        end
        fill_start = 1'b0;
        tick();
        chk("wrap_done", s_done, 1);
        chk("wrap_busy_done", s_busy, 0);
        tick(); tick(); tick();
        chk("wrap_done_once", done_cnt - d0, 1);
        chk("wrap_idle_after", s_busy, 0);
        chk("wrap_q_empty", exp_q.size(), 0);

        // CPU writes every cycle during a fill: fill wins every 5th cycle
        for (int c = 1; c <= 15; c++) begin
            if (c % 5 == 0) push_wr(10'h100 + 10'(c / 5 - 1), 8'h3C);
            else            push_wr(10'h010, 8'hA5);
        end
        start_fill(10'h100, 11'd3, 8'h3C);
        cpu_cs_l = 1'b0; cpu_we_l = 1'b0; cpu_addr = 10'h010; cpu_wdata = 8'hA5;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk($sformatf("starve_wait%0d", c), s_wait, (c % 5 == 0));
        end
        cpu_cs_l = 1'b1;
        tick();
        chk("starve_done", s_done, 1);
        chk("starve_q_empty", exp_q.size(), 0);

        // Fill armed outside vblank, paused when vblank drops
        vblank = 1'b0;
        start_fill(10'h040, 11'd6, 8'h11);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("arm%0d_busy", i), s_busy, 1);
            chk($sformatf("arm%0d_cs_l", i), s_cs_l, 1);
        end
        for (int i = 0; i < 6; i++) push_wr(10'h040 + 10'(i), 8'h11);
        vblank = 1'b1;
        tick();
        chk("arm_exit_cs_l", s_cs_l, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("vb_a%0d_addr", i), s_cs_l ? 10'h3FF : s_addr, 10'h040 + 10'(i));
        end
        vblank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("vb_pause%0d_cs_l", i), s_cs_l, 1);
            chk($sformatf("vb_pause%0d_busy", i), s_busy, 1);
        end
        vblank = 1'b1;
        for (int i = 3; i < 6; i++) begin
            tick();
            chk($sformatf("vb_b%0d_addr", i), s_cs_l ? 10'h3FF : s_addr, 10'h040 + 10'(i));
        end
        tick();
        chk("vb_done", s_done, 1);
        chk("vb_q_empty", exp_q.size(), 0);

        // Zero-length fill
        d0 = done_cnt;
        start_fill(10'h300, 11'd0, 8'h99);
        chk("len0_start_cs_l", s_cs_l, 1);
        tick();
        chk("len0_done", s_done, 1);
        chk("len0_cs_l", s_cs_l, 1);
        tick();
        chk("len0_done_low", s_done, 0);
        chk("len0_done_once", done_cnt - d0, 1);

        // Full-playfield fill from 0x200
        for (int i = 0; i < 1024; i++) begin
            wr_hits[i] = 0;
            push_wr(10'(10'h200 + 10'(i)), 8'hC7);
        end
        start_fill(10'h200, 11'd1024, 8'hC7);
        n = 0; seen = 0;
        while (!seen && n < 1100) begin
            tick();
            n++;
            if (s_done) seen = 1;
        end
        chk("full_done_seen", seen, 1);
        chk("full_latency", n, 1025);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (wr_hits[i] != 1 || mem[i] !== 8'hC7) bad++;
        chk("full_each_once", bad, 0);
        chk("full_q_empty", exp_q.size(), 0);

        // Reset with 37 tiles remaining
        for (int i = 0; i < 63; i++) push_wr(10'(i), 8'hEE);
        start_fill(10'h000, 11'd100, 8'hEE);
        repeat (63) tick();
        d0 = done_cnt;
        rst_l = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_l = 1'b1;
        w0 = wr_cnt;
        repeat (20) tick();
        chk("midrst_no_writes", wr_cnt - w0, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_busy", s_busy, 0);
        chk("midrst_mem_last", mem[62], 8'hEE);
        chk("midrst_mem_next", mem[63], 8'hC7);
        chk("final_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
